ring_token_ctrl: RTL and testbench
==================================

// Module: ring_token_ctrl
// PURPOSE
//   Cycle-level model of a unidirectional token ring of N_NODES nodes under
//   environment fault injection. Upstream producer for the ring requirement
//   monitor: its loss and ring_reset outputs drive the monitor's loss/reset
//   inputs, and its hop pulses mark forward progress. env_* inputs are
//   uncontrollable (tester-driven); ctrl_regen is the controllable action.
// PARAMETERS
//   N_NODES  8  nodes in the ring; token_pos wraps N_NODES-1 -> 0
//   IDW      3  width of token_pos; must satisfy 2**IDW >= N_NODES
//   TIMEOUT  4  cycles in LOST before a forced restart; must be >= 1
// PORTS
//   clk         in   1    clock, all state updates on posedge
//   reset       in   1    synchronous, active-high
//   env_drop    in   1    environment drops the token on the current hop
//   env_kill    in   1    environment forces a ring restart
//   ctrl_regen  in   1    controller regenerates a lost token
//   token_pos   out  IDW  node holding the token
//   token_valid out  1    1 iff state==PASS
//   hop         out  1    registered 1-cycle pulse, token advanced last edge
//   loss        out  1    1 iff state==LOST (feeds monitor loss)
//   ring_reset  out  1    1 iff state==RESTART (feeds monitor reset)
//   laps        out  8    completed wraps since last restart, saturates at 255
// BEHAVIOUR
//   Reset (sync, highest priority): state=INIT, token_pos=0, timer=0, laps=0,
//     hop=0; so token_valid=loss=ring_reset=0. Inputs ignored while reset=1.
//   States: INIT, PASS, LOST, RESTART (2-bit encoding). Outputs other than
//     hop/token_pos/laps are decoded from state (Moore, no input paths).
//   INIT: unconditional -> PASS next edge. hop<=0. One idle cycle after reset.
//   PASS, priority env_kill > env_drop > advance:
//     env_kill: -> RESTART, hop<=0, token_pos holds.
//     env_drop: -> LOST, timer<=0, hop<=0, token_pos holds.
//     else advance: token_pos<=(token_pos==N_NODES-1)?0:token_pos+1, hop<=1;
//       on wrap laps<=laps+1 unless laps==255.
//   LOST, priority env_kill > ctrl_regen > timeout:
//     env_kill: -> RESTART.
//     ctrl_regen: -> PASS, token_pos holds, no hop this edge.
//     timer==TIMEOUT-1: -> RESTART. else timer<=timer+1.
//     hop<=0 every edge in LOST. timer width clog2(TIMEOUT)+1.
//   RESTART: exactly one cycle; token_pos<=0, laps<=0, timer<=0, -> PASS.
//     Inputs ignored in RESTART (env_kill/env_drop have no effect).
//   ctrl_regen ignored outside LOST; env_drop ignored outside PASS.
//   Simultaneous env_drop+env_kill in PASS: kill wins, no LOST cycle seen.
//   Reset mid-LOST or mid-RESTART: returns to INIT; timer/laps cleared.
//   Latency: input sampled at edge t; state/hop visible after edge t.
//   Progress per lap: N_NODES hops; monitor sees loss high for every LOST
//     cycle and ring_reset high for exactly one cycle per restart.
// TESTING
//   T1 reset 1 cycle, all env/ctrl 0 for 10 edges -> INIT 1 cycle, then
//      token_pos 0,1,..,7,0,1; hop=1 from 2nd edge; laps=1 after the wrap.
//   T2 in PASS at pos 3, env_drop 1 cycle, no regen -> loss=1 for 4 cycles,
//      ring_reset=1 for 1 cycle, then PASS with token_pos=0, laps=0.
//   T3 in PASS at pos 5, env_drop, ctrl_regen on 2nd LOST cycle -> loss=1 for
//      2 cycles, PASS resumes at pos 5, next hop to 6.
//   T4 env_drop and env_kill same cycle in PASS -> no loss cycle,
//      ring_reset=1 one cycle, token_pos=0.
//   T5 run 8*256+8 hops without faults -> laps saturates at 255, no wrap to 0.
//   T6 reset asserted during LOST (timer=2) -> INIT next edge, loss=0,
//      token_pos=0; next drop again needs full TIMEOUT=4 cycles to restart.

Source files
------------

// File: rtl/ring_token_ctrl.sv
// ring_token_ctrl: token ring model with drop/kill fault injection, regen and timeout restart
module ring_token_ctrl #(
  parameter int N_NODES = 8,
  parameter int IDW = 3,
  parameter int TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           env_drop,
  input  logic           env_kill,
  input  logic           ctrl_regen,
  output logic [IDW-1:0] token_pos,
  output logic           token_valid,
  output logic           hop,
  output logic           loss,
  output logic           ring_reset,
  output logic [7:0]     laps
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {INIT, PASS, LOST, RESTART} state_t;
  state_t state, state_n;
  logic [IDW-1:0] pos_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0] laps_n;
  logic hop_n, wrap;
  assign wrap = token_pos == IDW'(N_NODES - 1);
  always_comb begin
    state_n = state;
    pos_n = token_pos;
    timer_n = timer;
    laps_n = laps;
    hop_n = 1'b0;
    case (state)
      INIT: state_n = PASS;
      PASS:
        if (env_kill) state_n = RESTART;
        else if (env_drop) begin
          state_n = LOST;
          timer_n = '0;
        end else begin
          pos_n = wrap ? '0 : token_pos + 1'b1;
          hop_n = 1'b1;
          laps_n = (wrap && laps != 8'hff) ? laps + 8'd1 : laps;
        end
      LOST:
        if (env_kill) state_n = RESTART;
        else if (ctrl_regen) state_n = PASS;
        else if (timer == TW'(TIMEOUT - 1)) state_n = RESTART;
        else timer_n = timer + 1'b1;
      default: begin
        pos_n = '0;
        laps_n = '0;
        timer_n = '0;
        state_n = PASS;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      token_pos <= '0;
      timer <= '0;
      laps <= '0;
      hop <= 1'b0;
    end else begin
      state <= state_n;
      token_pos <= pos_n;
      timer <= timer_n;
      laps <= laps_n;
      hop <= hop_n;
    end
  end
  assign token_valid = state == PASS;
  assign loss = state == LOST;
  assign ring_reset = state == RESTART;
endmodule

// File: tb/tb_ring_token_ctrl.sv
// tb_ring_token_ctrl: directed + random stimulus checked against a behavioural ring model
module tb_ring_token_ctrl;
  localparam int N = 8;
  localparam int TO = 4;
  logic clk, reset, env_drop, env_kill, ctrl_regen;
  logic [2:0] token_pos;
  logic token_valid, hop, loss, ring_reset;
  logic [7:0] laps;
  int compared = 0, mismatched = 0;
  // model: phase names are the bench's own, lost_age counts cycles spent lost
  localparam int IDLE = 10, RUNNING = 11, DROPPED = 12, RESTARTING = 13;
  int m_phase = IDLE, m_pos = 0, m_laps = 0, m_hop = 0, lost_age = 0;

  ring_token_ctrl #(.N_NODES(N), .IDW(3), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .env_drop(env_drop), .env_kill(env_kill),
    .ctrl_regen(ctrl_regen), .token_pos(token_pos), .token_valid(token_valid),
    .hop(hop), .loss(loss), .ring_reset(ring_reset), .laps(laps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit d, input bit k, input bit g);
    m_hop = 0;
    if (r) begin
      m_phase = IDLE; m_pos = 0; m_laps = 0; lost_age = 0;
    end else if (m_phase == IDLE) m_phase = RUNNING;
    else if (m_phase == RUNNING) begin
      if (k) m_phase = RESTARTING;
      else if (d) begin m_phase = DROPPED; lost_age = 0; end
      else begin
        m_hop = 1;
        m_pos = (m_pos + 1) % N;
        if (m_pos == 0 && m_laps < 255) m_laps++;
      end
    end else if (m_phase == DROPPED) begin
      if (k || (!g && lost_age + 1 >= TO)) m_phase = RESTARTING;
      else if (g) m_phase = RUNNING;
      else lost_age++;
    end else begin
      m_pos = 0; m_laps = 0; lost_age = 0; m_phase = RUNNING;
    end
  endtask

  task automatic cyc(input bit r, input bit d, input bit k, input bit g);
    reset = r; env_drop = d; env_kill = k; ctrl_regen = g;
    @(posedge clk);
    model(r, d, k, g);
    #1;
    chk("token_pos", int'(token_pos), m_pos);
    chk("laps", int'(laps), m_laps);
    chk("hop", int'(hop), m_hop);
    chk("token_valid", int'(token_valid), int'(m_phase == RUNNING));
    chk("loss", int'(loss), int'(m_phase == DROPPED));
    chk("ring_reset", int'(ring_reset), int'(m_phase == RESTARTING));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; env_drop = 1'b0; env_kill = 1'b0; ctrl_regen = 1'b0;
    // T1: reset, then free running through one wrap
    cyc(1, 0, 0, 0);
    chk("rst_pos", int'(token_pos), 0);
    chk("rst_loss", int'(loss | ring_reset | token_valid | hop), 0);
    cyc(0, 0, 0, 0);
    chk("init_hop", int'(hop), 0);
    idle(9);
    chk("t1_pos", int'(token_pos), 1);
    chk("t1_laps", int'(laps), 1);
    // T2: drop at pos 3, timeout restart
    cyc(1, 0, 0, 0); idle(4);
    chk("t2_pos3", int'(token_pos), 3);
    cyc(0, 1, 0, 0); idle(3);
    chk("t2_lost4", int'(loss), 1);
    cyc(0, 0, 0, 0);
    chk("t2_restart", int'(ring_reset), 1);
    cyc(0, 0, 0, 0);
    chk("t2_pass_pos", int'(token_pos), 0);
    chk("t2_pass_laps", int'(laps), 0);
    // T3: drop at pos 5, regen on 2nd lost cycle
    idle(5);
    chk("t3_pos5", int'(token_pos), 5);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    chk("t3_resume", int'(token_valid), 1);
    chk("t3_pos", int'(token_pos), 5);
    cyc(0, 0, 0, 0);
    chk("t3_next", int'(token_pos), 6);
    // T4: drop and kill together
    cyc(0, 1, 1, 0);
    chk("t4_noloss", int'(loss), 0);
    chk("t4_restart", int'(ring_reset), 1);
    cyc(0, 0, 0, 0);
    chk("t4_pos", int'(token_pos), 0);
    // T5: laps saturation
    idle(8 * 256 + 8);
    chk("t5_sat", int'(laps), 255);
    // T6: reset during LOST with timer=2
    cyc(0, 1, 0, 0); idle(2);
    cyc(1, 0, 0, 0);
    chk("t6_loss", int'(loss), 0);
    chk("t6_pos", int'(token_pos), 0);
    idle(2);
    cyc(0, 1, 0, 0); idle(3);
    chk("t6_still_lost", int'(loss), 1);
    cyc(0, 0, 0, 0);
    chk("t6_restart", int'(ring_reset), 1);
    // random fault injection
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(63) == 0, $urandom_range(7) == 0,
          $urandom_range(15) == 0, $urandom_range(3) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
